// File: rtl/pcie_dllp_tx_scheduler.sv
// ---------------------------------------------------------------------------
// pcie_dl_pkg / pcie_dllp_tx_scheduler
//
// Purpose:
//   Schedules every DLLP the data link layer transmits. During flow-control
//   initialisation it sequences InitFC1 and then InitFC2 triplets (P, NP, Cpl),
//   repeating each triplet after an idle gap until the link-init controller
//   reports DL_UP / DL_ACTIVE. Once active it arbitrates Ack/Nak (highest
//   priority) and round-robin UpdateFC requesters onto a single valid/ready
//   DLLP port feeding the CRC/framing stage.
//
// Optional feature (compile-time macro):
//   DLLP_SCHED_UPDATEFC_TIMER_EN - periodic UpdateFC refresh. When defined, a
//   counter running in ST_ACTIVE marks all three types pending every
//   UPDATEFC_PERIOD cycles without an UpdateFC handshake. When undefined,
//   UpdateFC is only sent on updatefc_req_i and no counter exists.
//
// Parameters:
//   FC_RESEND_CYCLES  idle cycles between InitFC triplet repeats (>= 1)
//   UPDATEFC_PERIOD   UpdateFC refresh period (timer build only, >= 1)
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   soft_reset_i          link-down abort: back to ST_IDLE next cycle
//   init_flow_control_i   FC initialisation enable
//   link_status_i         DL_DOWN / DL_UP / DL_ACTIVE
//   hdr_credit_i[3]       advertised header credits (0=P, 1=NP, 2=Cpl)
//   data_credit_i[3]      advertised data credits, same indexing
//   ack_nak_req_i         Ack/Nak request level
//   ack_nak_is_nak_i      1 = Nak, 0 = Ack
//   ack_nak_seq_i         AckNak_Seq_Num
//   updatefc_req_i[3]     UpdateFC request level per type
//   ack_nak_gnt_o         1-cycle pulse after the Ack/Nak handshake
//   updatefc_gnt_o[3]     1-cycle pulse per type after its handshake
//   dllp_valid_o          DLLP valid
//   dllp_ready_i          downstream ready
//   dllp_o                {type, byte1, byte2, byte3}
//   fc_init_done_o        high while in ST_ACTIVE
// ---------------------------------------------------------------------------
package pcie_dl_pkg;
  typedef enum logic [1:0] {
    DL_DOWN   = 2'd0,
    DL_UP     = 2'd1,
    DL_ACTIVE = 2'd2
  } pcie_dl_status_e;
endpackage

module pcie_dllp_tx_scheduler
  import pcie_dl_pkg::*;
#(
  parameter int FC_RESEND_CYCLES = 8500,
  parameter int UPDATEFC_PERIOD  = 7500
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  soft_reset_i,
  input  logic                  init_flow_control_i,
  input  pcie_dl_status_e       link_status_i,
  input  logic [2:0][7:0]       hdr_credit_i,
  input  logic [2:0][11:0]      data_credit_i,
  input  logic                  ack_nak_req_i,
  input  logic                  ack_nak_is_nak_i,
  input  logic [11:0]           ack_nak_seq_i,
  input  logic [2:0]            updatefc_req_i,
  output logic                  ack_nak_gnt_o,
  output logic [2:0]            updatefc_gnt_o,
  output logic                  dllp_valid_o,
  input  logic                  dllp_ready_i,
  output logic [31:0]           dllp_o,
  output logic                  fc_init_done_o
);

  // Elaboration-time parameter guards.
  if (FC_RESEND_CYCLES < 1) begin : g_bad_fc_resend
    $error("FC_RESEND_CYCLES must be >= 1");
  end
  if (UPDATEFC_PERIOD < 1) begin : g_bad_updatefc_period
    $error("UPDATEFC_PERIOD must be >= 1");
  end

  localparam int TMR_W = (FC_RESEND_CYCLES > 1) ? $clog2(FC_RESEND_CYCLES + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FC_RESEND_CYCLES - 1);

  // VC0 type bytes; P/NP/Cpl are spaced by 0x10 from each base.
  localparam logic [7:0] INITFC1_BASE  = 8'h40;
  localparam logic [7:0] INITFC2_BASE  = 8'hC0;
  localparam logic [7:0] UPDATEFC_BASE = 8'h80;
  localparam logic [7:0] ACK_TYPE      = 8'h00;
  localparam logic [7:0] NAK_TYPE      = 8'h10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FC1_SEND,
    ST_FC1_WAIT,
    ST_FC2_SEND,
    ST_FC2_WAIT,
    ST_ACTIVE
  } state_e;

  // Flow-control DLLP: type byte = base + 0x10*idx, credits for that type.
  function automatic logic [31:0] fc_dllp(input logic [7:0]       base,
                                          input logic [1:0]       idx,
                                          input logic [2:0][7:0]  hdr,
                                          input logic [2:0][11:0] data);
    logic [7:0]  h;
    logic [11:0] d;
    case (idx)
      2'd1:    begin h = hdr[1]; d = data[1]; end
      2'd2:    begin h = hdr[2]; d = data[2]; end
      default: begin h = hdr[0]; d = data[0]; end
    endcase
    return {base + {2'b00, idx, 4'h0}, 2'b00, h[7:2], h[1:0], 2'b00, d[11:8], d[7:0]};
  endfunction

  function automatic logic [31:0] acknak_dllp(input logic        is_nak,
                                              input logic [11:0] seq);
    return {(is_nak ? NAK_TYPE : ACK_TYPE), 8'h00, 4'h0, seq[11:8], seq[7:0]};
  endfunction

  // (base + off) mod 3 for the round-robin search.
  function automatic logic [1:0] rr_slot(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  state_e          state_q;
  logic [1:0]      fc_idx_q;
  logic [TMR_W-1:0] timer_q;
  logic [1:0]      rr_q;
  logic            cur_ack_q;
  logic [2:0]      cur_upd_q;
  logic            valid_q;
  logic [31:0]     dllp_q;
  logic            ack_gnt_q;
  logic [2:0]      upd_gnt_q;
  logic            done_q;

  logic            hs;
  logic [2:0]      upd_pend;
  logic            ack_eff;
  logic [2:0]      upd_eff;
  logic            upd_any;
  logic [1:0]      upd_sel;
  logic [7:0]      fc_base;

  assign hs      = valid_q && dllp_ready_i;
  assign fc_base = (state_q == ST_FC2_SEND) ? INITFC2_BASE : INITFC1_BASE;

  // A request is masked while its own DLLP is handshaking and during its
  // grant pulse, so a requester that drops the cycle after the pulse is
  // served exactly once even with back-to-back issue.
  always_comb begin
    ack_eff = ack_nak_req_i && !(hs && cur_ack_q) && !ack_gnt_q;
    upd_eff = (updatefc_req_i | upd_pend) & ~(cur_upd_q & {3{hs}}) & ~upd_gnt_q;
    upd_any = |upd_eff;
    upd_sel = rr_q;
    for (int k = 2; k >= 0; k--) begin
      if (upd_eff[rr_slot(rr_q, 2'(k))]) upd_sel = rr_slot(rr_q, 2'(k));
    end
  end

  always_ff @(posedge clk_i) begin
    ack_gnt_q <= 1'b0;
    upd_gnt_q <= 3'b000;
    if (rst_i) begin
      state_q   <= ST_IDLE;
      fc_idx_q  <= 2'd0;
      timer_q   <= '0;
      rr_q      <= 2'd0;
      cur_ack_q <= 1'b0;
      cur_upd_q <= 3'b000;
      valid_q   <= 1'b0;
      dllp_q    <= 32'h0;
      done_q    <= 1'b0;
    end else if (soft_reset_i) begin
      // Abort: the in-flight DLLP is dropped without a grant.
      state_q   <= ST_IDLE;
      fc_idx_q  <= 2'd0;
      timer_q   <= '0;
      rr_q      <= 2'd0;
      cur_ack_q <= 1'b0;
      cur_upd_q <= 3'b000;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (hs) begin
        ack_gnt_q <= cur_ack_q;
        upd_gnt_q <= cur_upd_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (init_flow_control_i) begin
            state_q  <= ST_FC1_SEND;
            fc_idx_q <= 2'd0;
            valid_q  <= 1'b1;
            dllp_q   <= fc_dllp(INITFC1_BASE, 2'd0, hdr_credit_i, data_credit_i);
          end
        end

        // A started triplet always completes; link status is only looked
        // at on the Cpl handshake.
        ST_FC1_SEND, ST_FC2_SEND: begin
          if (hs) begin
            if (fc_idx_q != 2'd2) begin
              fc_idx_q <= fc_idx_q + 2'd1;
              dllp_q   <= fc_dllp(fc_base, fc_idx_q + 2'd1, hdr_credit_i, data_credit_i);
            end else if (state_q == ST_FC1_SEND && link_status_i == DL_UP) begin
              state_q  <= ST_FC2_SEND;
              fc_idx_q <= 2'd0;
              dllp_q   <= fc_dllp(INITFC2_BASE, 2'd0, hdr_credit_i, data_credit_i);
            end else if (state_q == ST_FC2_SEND && link_status_i == DL_ACTIVE) begin
              state_q  <= ST_ACTIVE;
              valid_q  <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              state_q  <= (state_q == ST_FC1_SEND) ? ST_FC1_WAIT : ST_FC2_WAIT;
              valid_q  <= 1'b0;
              timer_q  <= '0;
            end
          end
        end

        // The timer value equals the number of idle cycles already spent
        // minus one, so issuing on TMR_LAST gives exactly FC_RESEND_CYCLES
        // low-valid cycles.
        ST_FC1_WAIT: begin
          if (link_status_i == DL_UP) begin
            state_q  <= ST_FC2_SEND;
            fc_idx_q <= 2'd0;
            valid_q  <= 1'b1;
            timer_q  <= '0;
            dllp_q   <= fc_dllp(INITFC2_BASE, 2'd0, hdr_credit_i, data_credit_i);
          end else if (timer_q == TMR_LAST) begin
            state_q  <= ST_FC1_SEND;
            fc_idx_q <= 2'd0;
            valid_q  <= 1'b1;
            timer_q  <= '0;
            dllp_q   <= fc_dllp(INITFC1_BASE, 2'd0, hdr_credit_i, data_credit_i);
          end else begin
            timer_q  <= timer_q + TMR_W'(1);
          end
        end

        ST_FC2_WAIT: begin
          if (link_status_i == DL_ACTIVE) begin
            state_q  <= ST_ACTIVE;
            done_q   <= 1'b1;
            timer_q  <= '0;
          end else if (timer_q == TMR_LAST) begin
            state_q  <= ST_FC2_SEND;
            fc_idx_q <= 2'd0;
            valid_q  <= 1'b1;
            timer_q  <= '0;
            dllp_q   <= fc_dllp(INITFC2_BASE, 2'd0, hdr_credit_i, data_credit_i);
          end else begin
            timer_q  <= timer_q + TMR_W'(1);
          end
        end

        // Pick a new DLLP whenever the port is empty or being emptied.
        ST_ACTIVE: begin
          if (!valid_q || hs) begin
            if (ack_eff) begin
              valid_q   <= 1'b1;
              cur_ack_q <= 1'b1;
              cur_upd_q <= 3'b000;
              dllp_q    <= acknak_dllp(ack_nak_is_nak_i, ack_nak_seq_i);
            end else if (upd_any) begin
              valid_q   <= 1'b1;
              cur_ack_q <= 1'b0;
              cur_upd_q <= 3'b001 << upd_sel;
              rr_q      <= (upd_sel == 2'd2) ? 2'd0 : upd_sel + 2'd1;
              dllp_q    <= fc_dllp(UPDATEFC_BASE, upd_sel, hdr_credit_i, data_credit_i);
            end else begin
              valid_q   <= 1'b0;
              cur_ack_q <= 1'b0;
              cur_upd_q <= 3'b000;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef DLLP_SCHED_UPDATEFC_TIMER_EN
  localparam int UFC_W = (UPDATEFC_PERIOD > 1) ? $clog2(UPDATEFC_PERIOD + 1) : 1;
  localparam logic [UFC_W-1:0] UFC_LAST = UFC_W'(UPDATEFC_PERIOD - 1);

  logic [UFC_W-1:0] ufc_cnt_q;
  logic [2:0]       ufc_pend_q;

  // Refresh timer: restarts on every UpdateFC handshake; on expiry all
  // three types become pending and drain through the normal arbiter.
  always_ff @(posedge clk_i) begin
    if (rst_i || soft_reset_i) begin
      ufc_cnt_q  <= '0;
      ufc_pend_q <= 3'b000;
    end else begin
      if (hs) ufc_pend_q <= ufc_pend_q & ~cur_upd_q;
      if (state_q != ST_ACTIVE) begin
        ufc_cnt_q <= '0;
      end else if (hs && (|cur_upd_q)) begin
        ufc_cnt_q <= '0;
      end else if (ufc_cnt_q == UFC_LAST) begin
        ufc_cnt_q  <= '0;
        ufc_pend_q <= 3'b111;
      end else begin
        ufc_cnt_q <= ufc_cnt_q + UFC_W'(1);
      end
    end
  end

  assign upd_pend = ufc_pend_q;
`else
  assign upd_pend = 3'b000;
`endif

  assign dllp_valid_o   = valid_q;
  assign dllp_o         = dllp_q;
  assign ack_nak_gnt_o  = ack_gnt_q;
  assign updatefc_gnt_o = upd_gnt_q;
  assign fc_init_done_o = done_q;

endmodule
